// File: rtl/input_conditioner_if.sv
// Raw button/switch inputs and their conditioned outputs, bundled between the
// board-facing source and the conditioner.
interface input_conditioner_if;
  logic        Raw_Key;
  logic [17:0] Raw_Switches;
  logic        Confirm;
  logic [17:0] Switches;
  logic        Press_Pulse;
  logic        Release_Pulse;
  logic        Switch_Changed;

  modport master (
    output Raw_Key, Raw_Switches,
    input  Confirm, Switches, Press_Pulse, Release_Pulse, Switch_Changed
  );

  modport slave (
    input  Raw_Key, Raw_Switches,
    output Confirm, Switches, Press_Pulse, Release_Pulse, Switch_Changed
  );
endinterface

// File: rtl/input_conditioner.sv
// Synchronizes and debounces a push button and an 18-bit switch bank; the
// switch word is frozen while the key is confirmed so the IO stage sees it stable.
module input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic                Slow_Clock,
  input  logic                Reset_N,
  input_conditioner_if.slave  io
);

  localparam int unsigned SW_W     = 18;
  localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0] CNT_PREV = 16'(DEBOUNCE_CYCLES - 2);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_t;

  // Assertion is immediate; release reaches the logic two edges later.
  logic [1:0] rst_sync_reg;
  logic       rst_n;

  always_ff @(posedge Slow_Clock or negedge Reset_N) begin
    if (!Reset_N) rst_sync_reg <= 2'b00;
    else          rst_sync_reg <= {rst_sync_reg[0], 1'b1};
  end

  assign rst_n = rst_sync_reg[1];

  logic [SYNC_STAGES-1:0] key_sync_reg;
  logic                   key_s;
  logic [SW_W-1:0]        sw_s;

  always_ff @(posedge Slow_Clock or negedge rst_n) begin
    if (!rst_n) key_sync_reg <= '1;
    else        key_sync_reg <= {key_sync_reg[SYNC_STAGES-2:0], io.Raw_Key};
  end

  assign key_s = ~key_sync_reg[SYNC_STAGES-1];

  genvar gi;
  generate
    for (gi = 0; gi < SW_W; gi++) begin : g_sw_sync
      logic [SYNC_STAGES-1:0] chain_reg;

      always_ff @(posedge Slow_Clock or negedge rst_n) begin
        if (!rst_n) chain_reg <= '0;
        else        chain_reg <= {chain_reg[SYNC_STAGES-2:0], io.Raw_Switches[gi]};
      end

      assign sw_s[gi] = chain_reg[SYNC_STAGES-1];
    end
  endgenerate

  key_state_t  state_reg, state_next;
  logic [15:0] cnt_reg, cnt_next;
  logic        confirm_reg, confirm_next;
  logic        press_pulse_reg, press_pulse_next;
  logic        release_pulse_reg, release_pulse_next;

  always_ff @(posedge Slow_Clock or negedge rst_n) begin
    if (!rst_n) begin
      state_reg         <= IDLE;
      cnt_reg           <= '0;
      confirm_reg       <= 1'b0;
      press_pulse_reg   <= 1'b0;
      release_pulse_reg <= 1'b0;
    end else begin
      state_reg         <= state_next;
      cnt_reg           <= cnt_next;
      confirm_reg       <= confirm_next;
      press_pulse_reg   <= press_pulse_next;
      release_pulse_reg <= release_pulse_next;
    end
  end

  always_comb begin
    state_next         = state_reg;
    cnt_next           = cnt_reg;
    confirm_next       = confirm_reg;
    press_pulse_next   = 1'b0;
    release_pulse_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (key_s) begin
          state_next = PRESS_WAIT;
          cnt_next   = 16'd1;
        end else begin
          cnt_next   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!key_s) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next       = PRESSED;
          confirm_next     = 1'b1;
          press_pulse_next = 1'b1;
          cnt_next         = '0;
        end else begin
          cnt_next = 16'(cnt_reg + 16'd1);
        end
      end
      PRESSED: begin
        if (!key_s) begin
          state_next = RELEASE_WAIT;
          cnt_next   = 16'd1;
        end else begin
          cnt_next   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (key_s) begin
          state_next = PRESSED;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next         = IDLE;
          confirm_next       = 1'b0;
          release_pulse_next = 1'b1;
          cnt_next           = '0;
        end else begin
          cnt_next = 16'(cnt_reg + 16'd1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Freeze tracks the registered Confirm so an update and a press acceptance
  // on the same edge both land, and the word holds until Confirm has fallen.
  logic            freeze;
  logic            sw_equal;
  logic [SW_W-1:0] cand_reg, cand_next;
  logic [15:0]     scnt_reg, scnt_next;
  logic [SW_W-1:0] switches_reg, switches_next;
  logic            sw_changed_reg, sw_changed_next;

  assign freeze   = confirm_reg;
  assign sw_equal = (sw_s == cand_reg);

  always_ff @(posedge Slow_Clock or negedge rst_n) begin
    if (!rst_n) begin
      cand_reg       <= '0;
      scnt_reg       <= '0;
      switches_reg   <= '0;
      sw_changed_reg <= 1'b0;
    end else begin
      cand_reg       <= cand_next;
      scnt_reg       <= scnt_next;
      switches_reg   <= switches_next;
      sw_changed_reg <= sw_changed_next;
    end
  end

  // The count reaching its last value on this edge is enough to accept, so
  // the switch path has the same sync+debounce latency as the key path.
  always_comb begin
    cand_next       = cand_reg;
    scnt_next       = scnt_reg;
    switches_next   = switches_reg;
    sw_changed_next = 1'b0;
    if (!sw_equal) begin
      cand_next = sw_s;
      scnt_next = '0;
    end else begin
      if (scnt_reg != CNT_LAST) scnt_next = 16'(scnt_reg + 16'd1);
      if (scnt_reg >= CNT_PREV && cand_reg != switches_reg && !freeze) begin
        switches_next   = cand_reg;
        sw_changed_next = 1'b1;
      end
    end
  end

  assign io.Confirm        = confirm_reg;
  assign io.Switches       = switches_reg;
  assign io.Press_Pulse    = press_pulse_reg;
  assign io.Release_Pulse  = release_pulse_reg;
  assign io.Switch_Changed = sw_changed_reg;

endmodule
